wb_mips8_mailbox: RTL

//  Wishbone classic responder that gives the management SoC a mailbox into the 8-bit MIPS core.

---
 rtl/wb_mips8_mailbox.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/wb_mips8_mailbox.sv
// rtl/wb_mips8_mailbox.sv - Wishbone mailbox between the management SoC and the 8-bit MIPS core
// Host bytes flow down to the core through one FIFO; 16-bit core results flow up through another.
module wb_mips8_mailbox #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          DEPTH     = 4
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic [7:0]  in_data_o,
    output logic        in_valid_o,
    input  logic        in_ready_i,
    input  logic [15:0] out_data_i,
    input  logic        out_valid_i,
    output logic        out_ready_o,
    output logic        irq_o
);
    localparam int         AW       = $clog2(DEPTH);
    localparam logic [3:0] FULL_CNT = 4'(DEPTH);

    logic [7:0]    down_mem [DEPTH];
    logic [15:0]   up_mem   [DEPTH];
    logic [AW-1:0] down_rd, down_wr, up_rd, up_wr;
    logic [3:0]    down_count, up_count;
    logic          ack, irq_en, ovf, unf, irq;
    logic [1:0]    reg_q;
    logic          we_q, sel_q;
    logic [7:0]    wdat_q;

    logic hit, req;
    logic down_empty, down_full, up_empty, up_full;
    logic tx_wr, rx_rd, ctrl_wr, flush, clr_err;
    logic down_push, down_pop, up_push, up_pop;
    logic unused_bits;

    assign hit = (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    assign req = wbs_cyc_i & wbs_stb_i & hit & ~ack;

    assign down_empty = (down_count == 4'd0);
    assign down_full  = (down_count == FULL_CNT);
    assign up_empty   = (up_count == 4'd0);
    assign up_full    = (up_count == FULL_CNT);

    // Side effects are taken from the request captured when it was accepted.
    assign tx_wr   = ack & we_q & (reg_q == 2'd0) & sel_q;
    assign rx_rd   = ack & ~we_q & (reg_q == 2'd1);
    assign ctrl_wr = ack & we_q & (reg_q == 2'd3) & sel_q;
    assign flush   = ctrl_wr & wdat_q[1];
    assign clr_err = ctrl_wr & wdat_q[2];

    // A pop on a full downstream FIFO frees the slot the same-cycle push lands in.
    assign down_pop  = ~down_empty & in_ready_i;
    assign down_push = tx_wr & (~down_full | down_pop);
    assign up_push   = out_valid_i & ~up_full;
    assign up_pop    = rx_rd & ~up_empty;

    assign wbs_ack_o   = ack;
    assign in_data_o   = down_mem[down_rd];
    assign in_valid_o  = ~down_empty;
    assign out_ready_o = ~up_full;
    assign irq_o       = irq;
    assign unused_bits = ^{wbs_sel_i[3:1], wbs_dat_i[31:8], wbs_adr_i[1:0]};

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            ack    <= 1'b0;
            reg_q  <= 2'd0;
            we_q   <= 1'b0;
            sel_q  <= 1'b0;
            wdat_q <= 8'h00;
        end else begin
            ack <= req;
            if (req) begin
                reg_q  <= wbs_adr_i[3:2];
                we_q   <= wbs_we_i;
                sel_q  <= wbs_sel_i[0];
                wdat_q <= wbs_dat_i[7:0];
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (down_push) down_mem[down_wr] <= wdat_q;
        if (up_push)   up_mem[up_wr]     <= out_data_i;
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            down_rd    <= '0;
            down_wr    <= '0;
            down_count <= 4'd0;
            up_rd      <= '0;
            up_wr      <= '0;
            up_count   <= 4'd0;
        end else if (flush) begin
            down_rd    <= '0;
            down_wr    <= '0;
            down_count <= 4'd0;
            up_rd      <= '0;
            up_wr      <= '0;
            up_count   <= 4'd0;
        end else begin
            if (down_push) down_wr <= down_wr + AW'(1);
            if (down_pop)  down_rd <= down_rd + AW'(1);
            if (up_push)   up_wr   <= up_wr + AW'(1);
            if (up_pop)    up_rd   <= up_rd + AW'(1);
            down_count <= down_count + {3'b000, down_push} - {3'b000, down_pop};
            up_count   <= up_count + {3'b000, up_push} - {3'b000, up_pop};
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            irq_en <= 1'b0;
            ovf    <= 1'b0;
            unf    <= 1'b0;
            irq    <= 1'b0;
        end else begin
            irq <= irq_en & ~up_empty;
            if (ctrl_wr) irq_en <= wdat_q[0];
            if (clr_err) begin
                ovf <= 1'b0;
                unf <= 1'b0;
            end else begin
                if (tx_wr && down_full && !down_pop) ovf <= 1'b1;
                if (rx_rd && up_empty)               unf <= 1'b1;
            end
        end
    end

    always_comb begin
        wbs_dat_o = 32'h0;
        if (ack && !we_q) begin
            case (reg_q)
                2'd1: if (!up_empty) wbs_dat_o = {16'h0, up_mem[up_rd]};
                2'd2: wbs_dat_o = {16'h0, up_count, down_count, 2'b00, unf, ovf,
                                   up_full, up_empty, down_full, down_empty};
                2'd3: wbs_dat_o = {31'h0, irq_en};
                default: wbs_dat_o = 32'h0;
            endcase
        end
    end
endmodule
